// File: rtl/fmadd_issue_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fmadd_issue_sequencer_if
// Brief    : Request, datapath and result signals of the FMA issue sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface fmadd_issue_sequencer_if #(
    parameter int STD = 31
);
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_op;
    logic [2:0]     in_rm;
    logic [STD:0]   in_A;
    logic [STD:0]   in_B;
    logic [STD:0]   in_C;
    logic           flush;
    logic           dp_act;
    logic [STD:0]   dp_A;
    logic [STD:0]   dp_B;
    logic [STD:0]   dp_C;
    logic [2:0]     dp_rm;
    logic [STD:0]   dp_result;
    logic [4:0]     dp_flags;
    logic           out_valid;
    logic           out_ready;
    logic [STD:0]   out_result;
    logic [4:0]     out_flags;
    logic           busy;

    // Environment side: requester, datapath and result consumer.
    modport master (
        output in_valid, in_op, in_rm, in_A, in_B, in_C, flush,
               dp_result, dp_flags, out_ready,
        input  in_ready, dp_act, dp_A, dp_B, dp_C, dp_rm,
               out_valid, out_result, out_flags, busy
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_op, in_rm, in_A, in_B, in_C, flush,
               dp_result, dp_flags, out_ready,
        output in_ready, dp_act, dp_A, dp_B, dp_C, dp_rm,
               out_valid, out_result, out_flags, busy
    );
endinterface
`default_nettype wire

// File: rtl/fmadd_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fmadd_issue_sequencer
// Brief    : Issues one FMA at a time to a fixed-latency datapath and holds
//            the registered result until the consumer accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module fmadd_issue_sequencer #(
    parameter int STD = 31,
    parameter int MAN = 22,
    parameter int EXP = 7,
    parameter int LAT = 3
) (
    input  wire logic               clk,
    input  wire logic               rst,
    fmadd_issue_sequencer_if.slave  bus
);
    localparam int c_SIGN = EXP + MAN + 2;
    localparam int c_CW   = $clog2(LAT + 1);
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CW-1:0]    r_cnt;
    logic               r_dp_act;
    logic [STD:0]       r_A;
    logic [STD:0]       r_B;
    logic [STD:0]       r_C;
    logic [2:0]         r_rm;
    logic               r_out_valid;
    logic [STD:0]       r_out_result;
    logic [4:0]         r_out_flags;

    logic               w_in_ready;
    logic               w_accept;
    logic [STD:0]       w_A;
    logic [STD:0]       w_C;

    always_comb begin
        w_in_ready = ~rst & ~bus.flush &
                     ((r_state == S_IDLE) | ((r_state == S_DONE) & bus.out_ready));
        w_accept   = w_in_ready & bus.in_valid;
        // op[1] negates the product (via A), op[0] negates the addend.
        w_A          = bus.in_A;
        w_A[c_SIGN]  = bus.in_A[c_SIGN] ^ bus.in_op[1];
        w_C          = bus.in_C;
        w_C[c_SIGN]  = bus.in_C[c_SIGN] ^ bus.in_op[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_dp_act     <= 1'b0;
            r_A          <= '0;
            r_B          <= '0;
            r_C          <= '0;
            r_rm         <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
        end else if (bus.flush) begin
            r_state     <= S_IDLE;
            r_dp_act    <= 1'b0;
            r_out_valid <= 1'b0;
            r_A         <= '0;
            r_B         <= '0;
            r_C         <= '0;
            r_rm        <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if ((r_state == S_DONE) && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                    if (w_accept) begin
                        r_state  <= S_EXEC;
                        r_cnt    <= c_CNT_LOAD;
                        r_dp_act <= 1'b1;
                        r_A      <= w_A;
                        r_B      <= bus.in_B;
                        r_C      <= w_C;
                        r_rm     <= bus.in_rm;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        // Operands drop to zero so the datapath idles on a clean input.
                        r_state      <= S_DONE;
                        r_dp_act     <= 1'b0;
                        r_out_valid  <= 1'b1;
                        r_out_result <= bus.dp_result;
                        r_out_flags  <= bus.dp_flags;
                        r_A          <= '0;
                        r_B          <= '0;
                        r_C          <= '0;
                        r_rm         <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.dp_act     = r_dp_act;
    assign bus.dp_A       = r_A;
    assign bus.dp_B       = r_B;
    assign bus.dp_C       = r_C;
    assign bus.dp_rm      = r_rm;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_flags  = r_out_flags;
    assign bus.busy       = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_fmadd_issue_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fmadd_issue_sequencer
// Brief    : Directed bench with a transaction-level model of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmadd_issue_sequencer;
    localparam int STD = 31;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   rst_req = 0;

    always #5 clk = ~clk;

    fmadd_issue_sequencer_if #(.STD(STD)) bif ();

    fmadd_issue_sequencer #(.STD(STD), .MAN(22), .EXP(7), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    // Datapath stand-in: exact results for the plan's operands, a hash otherwise.
    function automatic logic [31:0] dp_res(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        case ({a, b, c})
            {32'h3FC00000, 32'h40000000, 32'h3F800000}: return 32'h40800000;
            {32'h3FC00000, 32'h40000000, 32'hBF800000}: return 32'h40000000;
            {32'hBFC00000, 32'h40000000, 32'h3F800000}: return 32'hC0000000;
            {32'hBFC00000, 32'h40000000, 32'hBF800000}: return 32'hC0800000;
            default: return a ^ {b[15:0], b[31:16]} ^ (c + 32'h1);
        endcase
    endfunction

    function automatic logic [4:0] dp_flg(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        if (b == 32'h40000000 && a[30:0] == 31'h3FC00000 && c[30:0] == 31'h3F800000)
            return 5'b0;
        return {a[31], b[30], c[29], a[0], c[0]};
    endfunction

    assign bif.dp_result = bif.dp_act ? dp_res(bif.dp_A, bif.dp_B, bif.dp_C) : 32'hDEADBEEF;
    assign bif.dp_flags  = bif.dp_act ? dp_flg(bif.dp_A, bif.dp_B, bif.dp_C) : 5'h1F;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic        m_exec = 1'b0;
    logic        m_done = 1'b0;
    int          m_t0   = 0;
    int          cyc    = 0;
    int          rst_seen = 0;
    logic [31:0] m_A = '0, m_B = '0, m_C = '0, m_res = '0;
    logic [2:0]  m_rm  = '0;
    logic [4:0]  m_flg = '0;
    logic        pre_ready;

    initial begin
        forever begin
            @(posedge clk);
            if (rst || rst_seen != rst_req) begin
                rst_seen = rst_req;
                m_exec = 1'b0;
                m_done = 1'b0;
                m_res  = '0;
                m_flg  = '0;
                cyc    = 0;
            end else begin
                cyc++;
                pre_ready = !bif.flush && ((!m_exec && !m_done) || (m_done && bif.out_ready));
                if (bif.flush) begin
                    m_exec = 1'b0;
                    m_done = 1'b0;
                end else begin
                    if (m_exec && cyc == m_t0 + LAT) begin
                        m_exec = 1'b0;
                        m_done = 1'b1;
                        m_res  = dp_res(m_A, m_B, m_C);
                        m_flg  = dp_flg(m_A, m_B, m_C);
                    end else if (m_done && bif.out_ready) begin
                        m_done = 1'b0;
                    end
                    if (bif.in_valid && pre_ready) begin
                        m_exec = 1'b1;
                        m_done = 1'b0;
                        m_t0   = cyc;
                        m_A    = bif.in_A;
                        m_B    = bif.in_B;
                        m_C    = bif.in_C;
                        m_rm   = bif.in_rm;
                        case (bif.in_op)
                            2'b01: m_C[31] = ~m_C[31];
                            2'b10: m_A[31] = ~m_A[31];
                            2'b11: begin m_A[31] = ~m_A[31]; m_C[31] = ~m_C[31]; end
                            default: ;
                        endcase
                    end
                end
            end
            @(negedge clk);
            chk("m_in_ready", bif.in_ready,
                !rst && !bif.flush && ((!m_exec && !m_done) || (m_done && bif.out_ready)));
            chk("m_dp_act",     bif.dp_act,     m_exec);
            chk("m_dp_A",       bif.dp_A,       m_exec ? m_A : 32'h0);
            chk("m_dp_B",       bif.dp_B,       m_exec ? m_B : 32'h0);
            chk("m_dp_C",       bif.dp_C,       m_exec ? m_C : 32'h0);
            chk("m_dp_rm",      bif.dp_rm,      m_exec ? m_rm : 3'h0);
            chk("m_out_valid",  bif.out_valid,  m_done);
            chk("m_out_result", bif.out_result, m_res);
            chk("m_out_flags",  bif.out_flags,  m_flg);
            chk("m_busy",       bif.busy,       m_exec || m_done);
        end
    end

    // ---------------- directed stimulus ----------------
    localparam logic [31:0] A0 = 32'h3FC00000;
    localparam logic [31:0] B0 = 32'h40000000;
    localparam logic [31:0] C0 = 32'h3F800000;

    logic [31:0] ea [4] = '{32'h3FC00000, 32'h3FC00000, 32'hBFC00000, 32'hBFC00000};
    logic [31:0] ec [4] = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000};
    logic [31:0] er [4] = '{32'h40800000, 32'h40000000, 32'hC0000000, 32'hC0800000};

    logic [1:0]  bop [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
    logic [31:0] bA  [4] = '{A0, A0, A0, 32'h12345679};
    logic [31:0] bB  [4] = '{B0, B0, B0, 32'h0000FFFF};
    logic [31:0] bC  [4] = '{C0, C0, C0, 32'h80000001};
    logic [31:0] bR  [4] = '{32'h40800000, 32'h40000000, 32'hC0800000, 32'hEDCB567B};
    logic [4:0]  bF  [4] = '{5'b0, 5'b0, 5'b0, 5'b10011};

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [2:0] rm);
        bif.in_valid = 1'b1;
        bif.in_op    = op;
        bif.in_A     = a;
        bif.in_B     = b;
        bif.in_C     = c;
        bif.in_rm    = rm;
    endtask

    initial begin
        bif.in_valid  = 1'b0;
        bif.in_op     = 2'd0;
        bif.in_rm     = 3'd0;
        bif.in_A      = '0;
        bif.in_B      = '0;
        bif.in_C      = '0;
        bif.flush     = 1'b0;
        bif.out_ready = 1'b1;

        #3;
        chk("rst_in_ready",  bif.in_ready,   1'b0);
        chk("rst_busy",      bif.busy,       1'b0);
        chk("rst_out_valid", bif.out_valid,  1'b0);
        chk("rst_dp_act",    bif.dp_act,     1'b0);
        chk("rst_result",    bif.out_result, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bif.in_ready, 1'b1);
        tick();

        // Sign variants, one operation each with a 3-cycle activation window.
        for (int op = 0; op < 4; op++) begin
            req(op[1:0], A0, B0, C0, 3'(op + 1));
            tick();
            bif.in_valid = 1'b0;
            chk("sv_act_e0", bif.dp_act, 1'b1);
            chk("sv_dp_A",   bif.dp_A,   ea[op]);
            chk("sv_dp_B",   bif.dp_B,   B0);
            chk("sv_dp_C",   bif.dp_C,   ec[op]);
            tick();
            tick();
            chk("sv_act_e2", bif.dp_act, 1'b1);
            tick();
            chk("sv_out_valid", bif.out_valid,  1'b1);
            chk("sv_result",    bif.out_result, er[op]);
            chk("sv_act_off",   bif.dp_act,     1'b0);
            tick();
            chk("sv_valid_drop", bif.out_valid, 1'b0);
        end

        // Backpressure: result held, new request ignored until out_ready.
        bif.out_ready = 1'b0;
        req(2'd0, A0, B0, C0, 3'd0);
        tick();
        bif.in_valid = 1'b0;
        tick();
        tick();
        tick();
        req(2'd3, A0, B0, C0, 3'd2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",    bif.out_valid,  1'b1);
            chk("bp_result",   bif.out_result, 32'h40800000);
            chk("bp_flags",    bif.out_flags,  5'b0);
            chk("bp_in_ready", bif.in_ready,   1'b0);
            tick();
        end
        bif.out_ready = 1'b1;
        #1;
        chk("bp_ready_release", bif.in_ready, 1'b1);
        tick();
        bif.in_valid = 1'b0;
        chk("bp_new_dp_A", bif.dp_A,      32'hBFC00000);
        chk("bp_old_gone", bif.out_valid, 1'b0);
        tick();
        tick();
        tick();
        chk("bp_new_result", bif.out_result, 32'hC0800000);
        tick();

        // Back-to-back with out_ready held high.
        req(bop[0], bA[0], bB[0], bC[0], 3'd4);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k < 3) req(bop[k+1], bA[k+1], bB[k+1], bC[k+1], 3'd4);
            else bif.in_valid = 1'b0;
            tick();
            tick();
            chk("b2b_early", bif.out_valid, 1'b0);
            tick();
            chk("b2b_valid",  bif.out_valid,  1'b1);
            chk("b2b_result", bif.out_result, bR[k]);
            chk("b2b_flags",  bif.out_flags,  bF[k]);
        end
        tick();

        // Flush during EXEC.
        req(2'd0, A0, B0, C0, 3'd1);
        tick();
        bif.in_valid = 1'b0;
        tick();
        bif.flush = 1'b1;
        tick();
        bif.flush = 1'b0;
        chk("fe_act",  bif.dp_act, 1'b0);
        chk("fe_busy", bif.busy,   1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fe_no_valid", bif.out_valid, 1'b0);
        end

        // Flush in DONE together with out_ready and a new request.
        bif.out_ready = 1'b0;
        req(2'd1, A0, B0, C0, 3'd1);
        tick();
        bif.in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("fd_valid", bif.out_valid, 1'b1);
        bif.flush     = 1'b1;
        bif.out_ready = 1'b1;
        req(2'd0, A0, B0, C0, 3'd1);
        #1;
        chk("fd_in_ready", bif.in_ready, 1'b0);
        tick();
        bif.flush    = 1'b0;
        bif.in_valid = 1'b0;
        chk("fd_valid_drop", bif.out_valid, 1'b0);
        chk("fd_busy",       bif.busy,      1'b0);
        chk("fd_act",        bif.dp_act,    1'b0);

        // Flush with a request in IDLE.
        bif.flush = 1'b1;
        req(2'd0, A0, B0, C0, 3'd1);
        #1;
        chk("fi_in_ready", bif.in_ready, 1'b0);
        tick();
        bif.flush    = 1'b0;
        bif.in_valid = 1'b0;
        chk("fi_busy", bif.busy,   1'b0);
        chk("fi_act",  bif.dp_act, 1'b0);
        tick();

        // Asynchronous reset pulse between edges mid-EXEC.
        req(2'd2, A0, B0, C0, 3'd5);
        tick();
        bif.in_valid = 1'b0;
        tick();
        chk("ar_act_before", bif.dp_act, 1'b1);
        rst = 1'b1;
        rst_req++;
        #1;
        chk("ar_act",      bif.dp_act,    1'b0);
        chk("ar_valid",    bif.out_valid, 1'b0);
        chk("ar_busy",     bif.busy,      1'b0);
        chk("ar_dp_A",     bif.dp_A,      32'h0);
        chk("ar_in_ready", bif.in_ready,  1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_in_ready_after", bif.in_ready, 1'b1);
        tick();
        chk("ar_busy_after", bif.busy, 1'b0);

        // Recovery after reset.
        req(2'd1, A0, B0, C0, 3'd0);
        tick();
        bif.in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("rec_result", bif.out_result, 32'h40000000);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #50000;
        n_fail++;
        $display("FAIL timeout: got no end expected end by %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/fmadd_issue_sequencer.md
# fmadd_issue_sequencer

Issue/sequencing controller that sits in front of the fused multiply-add datapath (mantissa generator → multiplier → adder → normalise/round). It accepts one FMA operation at a time over a valid/ready handshake, applies the operation's sign variant to the operands, and drives the datapath activation signal for exactly the datapath's fixed latency. It then captures the result and flags into an output register and holds them until the consumer accepts. A synchronous flush aborts any in-flight operation.

## Interface
- `std`, 31: MSB index of an IEEE operand (32-bit single precision).
- `man`, 22: MSB index of the stored mantissa field.
- `exp`, 7: exponent field width minus 1.
- `LAT`, 3: datapath latency in cycles, ≥1. Activation is held for LAT cycles.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: sequencer can accept a request.
- `in_op` input 2: 00 fmadd, 01 fmsub, 10 fnmsub, 11 fnmadd.
- `in_rm` input 3: rounding mode, passed through to the datapath.
- `in_A`, `in_B`, `in_C` input std+1 each: IEEE operands. Result = A·B+C.
- `flush` input 1: synchronous abort.
- `dp_act` output 1: activation signal to the datapath.
- `dp_A`, `dp_B`, `dp_C` output std+1 each: operands to the datapath, sign-adjusted.
- `dp_rm` output 3: rounding mode to the datapath.
- `dp_result` input std+1: datapath result.
- `dp_flags` input 5: datapath flags in the order {NV,DZ,OF,UF,NX}.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_result` output std+1: registered result.
- `out_flags` output 5: registered flags.
- `busy` output 1: high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and DONE. It is one-hot or binary; the choice is free.
- **IDLE.** `in_ready`=1. When `in_valid` is high, the sequencer:
  - latches the operands into the operand registers;
  - loads `cnt`=LAT-1;
  - goes to EXEC.
- **Sign variants** are applied at latch time, unconditionally, including on NaN/zero:
  - fmsub: C sign inverted.
  - fnmsub: A sign inverted (product negated).
  - fnmadd: both A and C signs inverted.
  - B is never modified.
- **EXEC.** `dp_act`=1 and operand registers are held stable. `cnt` decrements each cycle.
  - When `cnt`==0, the next edge captures `dp_result`/`dp_flags` into the output registers and goes to DONE.
- **DONE.** `out_valid`=1 and the output registers are held.
  - If `out_ready` is high, the result is accepted.
  - Same cycle, if `in_valid` is also high, a new request is accepted: `in_ready` = IDLE | (DONE & `out_ready`), and the FSM goes to EXEC with new operands.
  - Otherwise the FSM goes to IDLE.
- **Datapath outputs when not in EXEC.** `dp_act`=0 and `dp_A`/`dp_B`/`dp_C`/`dp_rm` are forced to all-zero, so the datapath sees a deactivated zero input.
- **flush.** Priority above all transitions: next state is IDLE, and `out_valid`, `dp_act` and the operand registers are cleared.
  - A request presented in the flush cycle is not accepted: `in_ready` is gated to 0 while `flush`=1.
  - A pending DONE result is discarded.
- **cnt** width is $clog2(LAT+1). It never wraps: it is reloaded only on accept.

## Timing
- **Reset values.** With `rst` high, asynchronously:
  - state=IDLE, `cnt`=0;
  - `dp_act`=0, `dp_A`/`dp_B`/`dp_C`=0, `dp_rm`=0;
  - `out_valid`=0, `out_result`=0, `out_flags`=0, `busy`=0;
  - `in_ready`=1 after deassertion; it is 0 while `rst` is high.
- **Latency.** For a request accepted at edge E:
  - `dp_act`=1 during cycles E..E+LAT-1;
  - the result is sampled at edge E+LAT;
  - `out_valid`=1 from E+LAT.
- **Throughput.** One operation per LAT+1 cycles with `out_ready` held high.
- **Backpressure.** `out_result`/`out_flags` remain stable while `out_valid` is high and `out_ready` is low. No new request is accepted during this time.
- **Reset mid-EXEC.** The operation is lost and all outputs return to their reset values immediately.
- **Simultaneous `flush` and `out_ready` in DONE.** Flush wins and the FSM goes to IDLE. The result counts as dropped; it is not an extra transfer.

## Test plan
- **fmadd, LAT=3.** A=0x3FC00000, B=0x40000000, C=0x3F800000, op=00, accepted at edge 0.
  - `dp_act` is high for cycles 0-2 with `dp_C`=0x3F800000.
  - The datapath model returns 0x40800000 with flags 0.
  - `out_valid` rises at edge 3 with `out_result`=0x40800000.
- **Sign variants.** Same operands with op=01, 10 and 11.
  - op=01: `dp_C`=0xBF800000, `dp_A`=0x3FC00000.
  - op=10: `dp_A`=0xBFC00000, `dp_C`=0x3F800000.
  - op=11: `dp_A`=0xBFC00000, `dp_C`=0xBF800000.
  - `dp_B` is 0x40000000 in all cases.
- **Backpressure.** `out_ready`=0 for 5 cycles after `out_valid`.
  - Result and flags are stable, `in_ready`=0, and `in_valid` is ignored.
  - Raising `out_ready` together with `in_valid` accepts the next operation in the same cycle.
- **Back-to-back.** Four requests with `out_ready`=1 throughout produce `out_valid` pulses at edges 3, 7, 11 and 15, with results in order.
- **Flush.**
  - Asserting `flush` at cycle 1 of EXEC: next cycle `dp_act`=0 and the state is IDLE; no `out_valid` ever appears for that operation.
  - Asserting `flush` in DONE drops `out_valid`.
  - `flush` together with `in_valid` in IDLE does not accept.
- **Async reset mid-EXEC.** `rst` pulsed between edges drives `dp_act`=0, `out_valid`=0 and `busy`=0 before the next edge. After release, `in_ready`=1.
